// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder with valid/ready handshakes, programmable wait latency and sub-word access.
// Optional DMEM_MISALIGN_ERR_EN flags misaligned half/word accesses as errors instead of aligning them down.
module dmem_responder #(
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] ADDR_BASE   = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);
  localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t r_state, w_next;
  logic        r_we, r_uns, r_err;
  logic [1:0]  r_size;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [3:0]  r_cnt;
  logic [31:0] r_mem [DEPTH_WORDS];
  logic        w_accept, w_commit, w_err, w_mis, w_we, w_uns;
  logic [1:0]  w_size;
  logic [31:0] w_addr, w_wdata, w_off, w_a, w_word, w_wdat, w_load;
  logic [3:0]  w_strb;
  logic [AW-1:0] w_idx;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  assign w_accept = req_valid & req_ready;
  // With zero wait the commit edge is the accept edge, so fields come straight from the inputs in IDLE.
  assign w_we    = r_state == IDLE ? req_we       : r_we;
  assign w_size  = r_state == IDLE ? req_size     : r_size;
  assign w_uns   = r_state == IDLE ? req_unsigned : r_uns;
  assign w_addr  = r_state == IDLE ? req_addr     : r_addr;
  assign w_wdata = r_state == IDLE ? req_wdata    : r_wdata;
  assign w_off   = w_addr - ADDR_BASE;
`ifdef DMEM_MISALIGN_ERR_EN
  assign w_a   = w_off;
  assign w_mis = (w_size == 2'b01 & w_off[0]) | (w_size == 2'b10 & |w_off[1:0]);
`else
  assign w_a   = w_size == 2'b01 ? {w_off[31:1], 1'b0} : w_size == 2'b10 ? {w_off[31:2], 2'b00} : w_off;
  assign w_mis = 1'b0;
`endif
  assign w_err  = (w_size == 2'b11) | (w_off >= 32'(DEPTH_WORDS * 4)) | w_mis;
  assign w_idx  = w_a[AW+1:2];
  assign w_word = r_mem[w_idx];
  assign w_byte = w_word[8*w_a[1:0] +: 8];
  assign w_half = w_a[1] ? w_word[31:16] : w_word[15:0];
  assign w_load = w_size == 2'b00 ? {{24{~w_uns & w_byte[7]}}, w_byte} :
                  w_size == 2'b01 ? {{16{~w_uns & w_half[15]}}, w_half} : w_word;
  assign w_strb = w_size == 2'b00 ? 4'b0001 << w_a[1:0] : w_size == 2'b01 ? (w_a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign w_wdat = w_size == 2'b00 ? {4{w_wdata[7:0]}} : w_size == 2'b01 ? {2{w_wdata[15:0]}} : w_wdata;
  assign w_commit = (w_next == RESP) & (r_state != RESP) & ~reset;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_we    <= req_we;
        r_size  <= req_size;
        r_uns   <= req_unsigned;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_cnt   <= 4'd1;
      end else if (r_state == WAIT) r_cnt <= r_cnt + 4'd1;
      if (w_commit) begin
        r_rdata <= (w_err | w_we) ? 32'h0 : w_load;
        r_err   <= w_err;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (w_commit & w_we & ~w_err)
      for (int i = 0; i < 4; i++)
        if (w_strb[i]) r_mem[w_idx][8*i +: 8] <= w_wdat[8*i +: 8];
  end
  always_comb begin
    w_next = r_state == IDLE ? (w_accept ? (WAIT_CYCLES > 0 ? WAIT : RESP) : IDLE) :
             r_state == WAIT ? (r_cnt == 4'(WAIT_CYCLES) ? RESP : WAIT) :
             r_state == RESP ? (resp_ready ? IDLE : RESP) : IDLE;
  end
  always_comb begin
    req_ready  = (r_state == IDLE) & ~reset;
    resp_valid = r_state == RESP;
    resp_rdata = r_rdata;
    resp_err   = r_err;
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for dmem_responder; one instance with WAIT_CYCLES=1, one with WAIT_CYCLES=3.
module tb_dmem_responder;
  logic clk = 0, reset = 1, sel = 0;
  logic req_valid = 0, req_we = 0, req_unsigned = 0, resp_ready = 1;
  logic [1:0]  req_size = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic rdy0, rdy1, rv0, rv1, er0, er1, rdy, rv, er;
  logic [31:0] rd0, rd1, rd;
  int n_cmp = 0, n_bad = 0;
  typedef struct packed {logic err; logic [31:0] d;} exp_t;
  exp_t sb[$];
  always #5 clk = ~clk;
  dmem_responder #(.WAIT_CYCLES(1)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid & ~sel), .req_ready(rdy0), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv0), .resp_ready(resp_ready), .resp_rdata(rd0), .resp_err(er0));
  dmem_responder #(.WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .reset(reset), .req_valid(req_valid & sel), .req_ready(rdy1), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv1), .resp_ready(resp_ready), .resp_rdata(rd1), .resp_err(er1));
  assign rdy = sel ? rdy1 : rdy0;
  assign rv  = sel ? rv1 : rv0;
  assign rd  = sel ? rd1 : rd0;
  assign er  = sel ? er1 : er0;
  task automatic xact(input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] ed, input logic ee, input int hold, input string nm);
    exp_t e;
    int lat;
    logic [31:0] held;
    sb.push_back('{err: ee, d: ed});
    @(negedge clk);
    req_valid = 1; req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
    resp_ready = (hold == 0);
    lat = 0;
    while (!rdy && lat < 20) begin @(negedge clk); lat++; end
    n_cmp++;
    if (rdy !== 1'b1) begin n_bad++; $display("FAIL %s accept: req_ready=%b, required 1", nm, rdy); end
    @(negedge clk);
    req_valid = 0; req_we = ~we; req_size = ~sz; req_unsigned = ~uns; req_addr = ~a; req_wdata = ~wd;
    lat = 1;
    while (!rv && lat < 30) begin @(negedge clk); lat++; end
    e = sb.pop_front();
    n_cmp++;
    if (lat !== (sel ? 4 : 2)) begin n_bad++; $display("FAIL %s latency: got %0d cycles, required %0d", nm, lat, sel ? 4 : 2); end
    n_cmp++;
    if (rd !== e.d) begin n_bad++; $display("FAIL %s rdata: got %h, required %h", nm, rd, e.d); end
    n_cmp++;
    if (er !== e.err) begin n_bad++; $display("FAIL %s err: got %b, required %b", nm, er, e.err); end
    held = rd;
    for (int i = 0; i < hold; i++) begin
      req_valid = 1;
      @(negedge clk);
      n_cmp++;
      if ({rv, rdy, rd} !== {1'b1, 1'b0, held}) begin
        n_bad++; $display("FAIL %s stall: valid=%b ready=%b rdata=%h, required 1 0 %h", nm, rv, rdy, rd, held);
      end
    end
    req_valid = 0; resp_ready = 1;
    @(negedge clk);
    n_cmp++;
    if ({rv, rdy} !== 2'b01) begin n_bad++; $display("FAIL %s release: valid=%b ready=%b, required 0 1", nm, rv, rdy); end
  endtask
  task automatic test_reset;
    reset = 1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({rdy0, rv0, rd0, er0, rdy1, rv1} !== 38'h0) begin
      n_bad++; $display("FAIL reset_state: ready=%b valid=%b rdata=%h err=%b, required all 0", rdy0, rv0, rd0, er0);
    end
    reset = 0;
    @(negedge clk);
    n_cmp++;
    if ({rdy0, rdy1} !== 2'b11) begin n_bad++; $display("FAIL reset_release: ready=%b%b, required 11", rdy0, rdy1); end
  endtask
  task automatic test_word;
    xact(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 0, "store_word");
    xact(0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 0, "load_word");
  endtask
  task automatic test_byte_lanes;
    xact(1, 2'b10, 0, 32'h20, 32'h0, 32'h0, 0, 0, "clear_20");
    xact(1, 2'b00, 0, 32'h21, 32'h12345680, 32'h0, 0, 0, "store_byte");
    xact(0, 2'b00, 0, 32'h21, 32'h0, 32'hFFFFFF80, 0, 0, "load_byte_s");
    xact(0, 2'b00, 1, 32'h21, 32'h0, 32'h00000080, 0, 0, "load_byte_u");
    xact(0, 2'b10, 0, 32'h20, 32'h0, 32'h00008000, 0, 0, "load_word_20");
    xact(0, 2'b01, 0, 32'h20, 32'h0, 32'hFFFF8000, 0, 0, "load_half_s");
  endtask
  task automatic test_backpressure;
    xact(0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 5, "stall_load");
  endtask
  task automatic test_errors;
    xact(1, 2'b10, 0, 32'h0, 32'h11223344, 32'h0, 0, 0, "store_w0");
    xact(0, 2'b10, 0, 32'd1024, 32'h0, 32'h0, 1, 0, "range_load");
    xact(0, 2'b10, 0, 32'hFFFFFFFC, 32'h0, 32'h0, 1, 0, "range_wrap");
    xact(1, 2'b11, 0, 32'h0, 32'hFFFFFFFF, 32'h0, 1, 0, "illegal_size");
    xact(0, 2'b10, 0, 32'h0, 32'h0, 32'h11223344, 0, 0, "readback_w0");
  endtask
  task automatic test_misalign;
`ifdef DMEM_MISALIGN_ERR_EN
    xact(1, 2'b01, 0, 32'h13, 32'h0000ABCD, 32'h0, 1, 0, "mis_store");
    xact(0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 0, "mis_readback");
`else
    xact(1, 2'b01, 0, 32'h13, 32'h0000ABCD, 32'h0, 0, 0, "mis_store");
    xact(0, 2'b10, 0, 32'h10, 32'h0, 32'hABCDBEEF, 0, 0, "mis_readback");
`endif
  endtask
  task automatic test_reset_midop;
    logic seen;
    sel = 1;
    xact(1, 2'b10, 0, 32'h8, 32'hCAFE0000, 32'h0, 0, 0, "w3_store_old");
    @(negedge clk);
    req_valid = 1; req_we = 1; req_size = 2'b10; req_addr = 32'h8; req_wdata = 32'h1234;
    n_cmp++;
    if (rdy1 !== 1'b1) begin n_bad++; $display("FAIL midop_accept: ready=%b, required 1", rdy1); end
    @(negedge clk);
    req_valid = 0; reset = 1;
    @(negedge clk);
    reset = 0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin seen |= rv1; @(negedge clk); end
    n_cmp++;
    if (seen !== 1'b0) begin n_bad++; $display("FAIL midop_no_resp: resp_valid seen=%b, required 0", seen); end
    xact(0, 2'b10, 0, 32'h8, 32'h0, 32'hCAFE0000, 0, 0, "w3_load_old");
    sel = 0;
  endtask
  initial begin
    test_reset;
    test_word;
    test_byte_lanes;
    test_backpressure;
    test_errors;
    test_misalign;
    test_reset_midop;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
